// File: rtl/agnus_bitplane_dma.sv
// Agnus bitplane DMA sequencer: custom register decode, fetch-slot selection from beam
// position, per-plane chip-RAM pointers with post-increment and end-of-line modulo.
module agnus_bitplane_dma #(
    parameter int unsigned VSTART = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        aga,
    input  logic        ecs,
    input  logic        a1k,
    input  logic        sof,
    input  logic        dmaena,
    input  logic [10:0] vpos,
    input  logic [8:0]  hpos,
    output logic        dma,
    input  logic [7:0]  reg_address_in,
    input  logic [15:0] data_in,
    output logic [7:0]  reg_address_out,
    output logic [19:0] address_out
);

    // Custom register word addresses (byte address >> 1)
    localparam logic [7:0] AddrDdfstrt = 8'h49;
    localparam logic [7:0] AddrDdfstop = 8'h4A;
    localparam logic [7:0] AddrBplcon0 = 8'h80;
    localparam logic [7:0] AddrBpl1mod = 8'h84;
    localparam logic [7:0] AddrBpl2mod = 8'h85;
    localparam logic [7:0] AddrBpl1dat = 8'h88;
    localparam logic [3:0] AddrPtrPage = 4'h7;

    logic mode_aga;
    logic mode_ecs;
    logic mode_ocs;

    assign mode_aga = aga & ~a1k;
    assign mode_ecs = ecs & ~a1k;
    assign mode_ocs = ~mode_aga & ~mode_ecs;

    // Register state; pointers hold word addresses [20:1]
    logic [19:0] ptr_q [8];
    logic [19:0] ptr_d [8];
    logic        hires_q;
    logic [3:0]  bpu_q;
    logic [7:0]  ddfstrt_q;
    logic [7:0]  ddfstop_q;
    logic [15:0] bpl1mod_q;
    logic [15:0] bpl2mod_q;

    logic [7:0]  ddf_mask;
    assign ddf_mask = mode_ocs ? 8'hFC : 8'hFE;

    // Effective plane count after chipset-dependent clamping
    logic [3:0] bpu_eff;
    always_comb begin
        bpu_eff = bpu_q;
        if (mode_aga) begin
            if (bpu_q > 4'd8) bpu_eff = 4'd8;
        end else if (hires_q && bpu_q > 4'd4) begin
            bpu_eff = 4'd4;
        end else if (bpu_q > 4'd6) begin
            bpu_eff = 4'd6;
        end
    end

    // Fetch window
    logic [7:0] cck;
    logic [7:0] ddf_span;
    logic [5:0] units;
    logic [8:0] win_end;
    logic [7:0] rel;
    logic [2:0] slot;
    logic [4:0] unit_idx;
    logic       active;
    logic       last_unit;

    assign cck       = hpos[8:1];
    assign ddf_span  = ddfstop_q - ddfstrt_q;
    assign units     = {1'b0, ddf_span[7:3]} + 6'd1;
    assign win_end   = {1'b0, ddfstrt_q} + {units, 3'b000};
    assign rel       = cck - ddfstrt_q;
    assign slot      = rel[2:0];
    assign unit_idx  = rel[7:3];
    assign last_unit = ({1'b0, unit_idx} == (units - 6'd1));

    assign active = dmaena & ~sof & (vpos >= 11'(VSTART)) & (ddfstop_q >= ddfstrt_q)
                  & (cck >= ddfstrt_q) & ({1'b0, cck} < win_end);

    // Plane assigned to the current slot offset
    logic [3:0] plane;
    always_comb begin
        plane = 4'd1;
        if (hires_q) begin
            case (slot[1:0])
                2'd0:    plane = 4'd4;
                2'd1:    plane = 4'd2;
                2'd2:    plane = 4'd3;
                default: plane = 4'd1;
            endcase
        end else begin
            case (slot)
                3'd0:    plane = 4'd8;
                3'd1:    plane = 4'd4;
                3'd2:    plane = 4'd6;
                3'd3:    plane = 4'd2;
                3'd4:    plane = 4'd7;
                3'd5:    plane = 4'd3;
                3'd6:    plane = 4'd5;
                default: plane = 4'd1;
            endcase
        end
    end

    logic       slot_used;
    logic [2:0] plane_idx;
    logic       final_fetch;
    logic [15:0] mod_sel;
    logic [19:0] mod_words;

    assign slot_used   = active & (plane <= bpu_eff);
    assign plane_idx   = 3'(plane - 4'd1);
    // Hires planes appear twice per unit; the second half holds the last one
    assign final_fetch = last_unit & (~hires_q | slot[2]);
    assign mod_sel     = plane_idx[0] ? bpl2mod_q : bpl1mod_q;
    assign mod_words   = {{5{mod_sel[15]}}, mod_sel[15:1]};

    // Pointer writes and post-increment
    logic       pt_wr;
    logic [2:0] pt_idx;

    assign pt_idx = reg_address_in[3:1];
    assign pt_wr  = clk7_en & (reg_address_in[7:4] == AddrPtrPage)
                  & (mode_aga | ~(pt_idx[2] & pt_idx[1]));

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ptr_d[i] = ptr_q[i];
        end
        if (clk7_en && hpos[0] && slot_used) begin
            ptr_d[plane_idx] = ptr_q[plane_idx] + 20'd1 + (final_fetch ? mod_words : 20'd0);
        end
        // CPU write to the same half overrides the increment
        if (pt_wr) begin
            if (reg_address_in[0]) begin
                ptr_d[pt_idx][14:0] = data_in[15:1];
            end else begin
                ptr_d[pt_idx][19:15] = data_in[4:0];
                if (mode_ocs) ptr_d[pt_idx][19:18] = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hires_q   <= 1'b0;
            bpu_q     <= '0;
            ddfstrt_q <= '0;
            ddfstop_q <= '0;
            bpl1mod_q <= '0;
            bpl2mod_q <= '0;
        end else if (clk7_en) begin
            case (reg_address_in)
                AddrBplcon0: begin
                    hires_q <= data_in[15];
                    bpu_q   <= {mode_aga & data_in[4], data_in[14:12]};
                end
                AddrDdfstrt: ddfstrt_q <= data_in[7:0] & ddf_mask;
                AddrDdfstop: ddfstop_q <= data_in[7:0] & ddf_mask;
                AddrBpl1mod: bpl1mod_q <= {data_in[15:1], 1'b0};
                AddrBpl2mod: bpl2mod_q <= {data_in[15:1], 1'b0};
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        dma             = 1'b0;
        reg_address_out = 8'hFF;
        address_out     = '0;
        if (slot_used) begin
            dma             = 1'b1;
            reg_address_out = AddrBpl1dat + {5'd0, plane_idx};
            address_out     = ptr_q[plane_idx];
        end
    end

endmodule

// File: tb/tb_agnus_bitplane_dma.sv
// Directed bench for agnus_bitplane_dma: sweeps display lines and checks fetch slots,
// destination registers, pointer progression, gating, clamping and reset behaviour.
module tb_agnus_bitplane_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic        aga;
    logic        ecs;
    logic        a1k;
    logic        sof;
    logic        dmaena;
    logic [10:0] vpos;
    logic [8:0]  hpos;
    logic        dma;
    logic [7:0]  reg_address_in;
    logic [15:0] data_in;
    logic [7:0]  reg_address_out;
    logic [19:0] address_out;

    int checks = 0;
    int errors = 0;

    int          cnt;
    int          pmax;
    logic [19:0] a_first;
    logic [19:0] a_last;
    logic [7:0]  c_first;
    logic [7:0]  c_last;
    logic [7:0]  r_first;
    logic [31:0] seq;

    agnus_bitplane_dma #(.VSTART(25)) dut (
        .clk             (clk),
        .reset           (reset),
        .clk7_en         (clk7_en),
        .aga             (aga),
        .ecs             (ecs),
        .a1k             (a1k),
        .sof             (sof),
        .dmaena          (dmaena),
        .vpos            (vpos),
        .hpos            (hpos),
        .dma             (dma),
        .reg_address_in  (reg_address_in),
        .data_in         (data_in),
        .reg_address_out (reg_address_out),
        .address_out     (address_out)
    );

    always #18 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick7();
        clk7_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clk7_en = 1'b1;
        @(posedge clk);
        #1;
        clk7_en = 1'b0;
    endtask

    task automatic wr(input logic [8:0] byte_addr, input logic [15:0] val);
        reg_address_in = byte_addr[8:1];
        data_in        = val;
        tick7();
        reg_address_in = 8'hFF;
        data_in        = 16'h0000;
    endtask

    // One line from cck 0x30 to 0xDF, recording each fetch once (odd hpos half)
    task automatic sweep();
        cnt  = 0;
        pmax = 0;
        seq  = '0;
        a_first = '0; a_last = '0; c_first = '0; c_last = '0; r_first = '0;
        for (int h = 'h60; h <= 'h1BF; h++) begin
            hpos = 9'(h);
            #1;
            if (hpos[0] && dma) begin
                if (cnt == 0) begin
                    a_first = address_out;
                    c_first = hpos[8:1];
                    r_first = reg_address_out;
                end
                if (cnt < 8) seq = {seq[27:0], 4'(int'(reg_address_out) - 'h88 + 1)};
                if (int'(reg_address_out) - 'h88 + 1 > pmax) pmax = int'(reg_address_out) - 'h88 + 1;
                a_last = address_out;
                c_last = hpos[8:1];
                cnt++;
            end
            tick7();
        end
        hpos = 9'h060;
        #1;
    endtask

    task automatic setup_lores1(input logic [15:0] modv);
        wr(9'h100, 16'h1000);
        wr(9'h092, 16'h0038);
        wr(9'h094, 16'h00D0);
        wr(9'h0E0, 16'h0001);
        wr(9'h0E2, 16'h0000);
        wr(9'h108, modv);
    endtask

    initial begin
        reset = 1'b1; clk7_en = 1'b0; aga = 1'b0; ecs = 1'b0; a1k = 1'b0; sof = 1'b0;
        dmaena = 1'b1; vpos = 11'h040; hpos = 9'h060; reg_address_in = 8'hFF;
        data_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dma", 32'(dma), 32'h0);
        chk("reset_reg", 32'(reg_address_out), 32'hFF);
        chk("reset_addr", 32'(address_out), 32'h0);
        reset = 1'b0;

        // Lores single plane
        setup_lores1(16'h0000);
        sweep();
        chk("lores1_count", 32'(cnt), 32'd20);
        chk("lores1_first_cck", 32'(c_first), 32'h3F);
        chk("lores1_last_cck", 32'(c_last), 32'hD7);
        chk("lores1_reg", 32'(r_first), 32'h88);
        chk("lores1_first_addr", 32'(a_first), 32'h08000);
        chk("lores1_last_addr", 32'(a_last), 32'h08013);
        sweep();
        chk("lores1_ptr_end", 32'(a_first), 32'h08014);

        // Positive and negative modulo
        setup_lores1(16'h0010);
        sweep();
        sweep();
        chk("mod_pos_ptr", 32'(a_first), 32'h0801C);
        setup_lores1(16'hFFD8);
        sweep();
        sweep();
        chk("mod_neg_ptr", 32'(a_first), 32'h08000);

        // clk7_en low must hold the pointer
        setup_lores1(16'h0000);
        hpos = 9'h07F;
        #1;
        chk("hold_dma", 32'(dma), 32'h1);
        chk("hold_addr0", 32'(address_out), 32'h08000);
        clk7_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("hold_addr1", 32'(address_out), 32'h08000);
        tick7();
        hpos = 9'h08F;
        #1;
        chk("hold_next_addr", 32'(address_out), 32'h08001);

        // Reset mid-fetch
        reset = 1'b1;
        #1;
        chk("midreset_dma", 32'(dma), 32'h0);
        chk("midreset_reg", 32'(reg_address_out), 32'hFF);
        chk("midreset_addr", 32'(address_out), 32'h0);
        reset = 1'b0;
        tick7();
        chk("postreset_dma", 32'(dma), 32'h0);
        hpos = 9'h060;

        // Gating
        setup_lores1(16'h0000);
        dmaena = 1'b0;
        sweep();
        chk("gate_dmaena", 32'(cnt), 32'd0);
        dmaena = 1'b1;
        vpos = 11'd24;
        sweep();
        chk("gate_vstart_m1", 32'(cnt), 32'd0);
        vpos = 11'd25;
        sweep();
        chk("gate_vstart", 32'(cnt), 32'd20);
        vpos = 11'h040;
        wr(9'h094, 16'h0030);
        sweep();
        chk("gate_stop_lt_start", 32'(cnt), 32'd0);
        wr(9'h094, 16'h00D0);

        // Hires four planes
        wr(9'h100, 16'hC000);
        wr(9'h0E0, 16'h0002); wr(9'h0E2, 16'h0000);
        wr(9'h0E4, 16'h0003); wr(9'h0E6, 16'h0000);
        wr(9'h0E8, 16'h0004); wr(9'h0EA, 16'h0000);
        wr(9'h0EC, 16'h0005); wr(9'h0EE, 16'h0000);
        wr(9'h108, 16'h0000);
        sweep();
        chk("hires_count", 32'(cnt), 32'd160);
        chk("hires_order", seq, 32'h42314231);
        chk("hires_first_addr", 32'(a_first), 32'h28000);
        chk("hires_last_addr", 32'(a_last), 32'h10027);
        sweep();
        chk("hires_ptr4_end", 32'(a_first), 32'h28028);

        // Plane clamping
        wr(9'h100, 16'h7000);
        sweep();
        chk("clamp_lores_count", 32'(cnt), 32'd120);
        chk("clamp_lores_max", 32'(pmax), 32'd6);
        wr(9'h100, 16'hE000);
        sweep();
        chk("clamp_hires_count", 32'(cnt), 32'd160);
        chk("clamp_hires_max", 32'(pmax), 32'd4);

        // AGA planes 7 and 8
        aga = 1'b1;
        wr(9'h100, 16'h0010);
        sweep();
        chk("aga_count", 32'(cnt), 32'd160);
        chk("aga_max", 32'(pmax), 32'd8);
        chk("aga_order", seq, 32'h84627351);

        // High pointer bits by chipset mode
        a1k = 1'b1;
        wr(9'h100, 16'h1000);
        wr(9'h0E0, 16'h001F);
        wr(9'h0E2, 16'h0000);
        sweep();
        chk("ocs_pth_mask", 32'(a_first), 32'h38000);
        a1k = 1'b0; aga = 1'b0; ecs = 1'b1;
        wr(9'h0E0, 16'h001F);
        wr(9'h0E2, 16'h0000);
        sweep();
        chk("ecs_pth_full", 32'(a_first), 32'hF8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
